// File: rtl/sram_data_mem_ctrl_if.sv
// Pipeline-side data-memory request/response bundle between the execute/MEM
// stages and the SRAM data-memory controller.
interface sram_data_mem_ctrl_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output mem_read,
    output mem_write,
    output address,
    output wdata,
    input  rdata,
    input  ready
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  address,
    input  wdata,
    output rdata,
    output ready
  );
endinterface

// File: rtl/sram_data_mem_ctrl.sv
// MEM-stage data-memory controller: each 32-bit access becomes two 16-bit
// external SRAM accesses (low half first) while ready holds the pipeline.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no access in flight; ready high unless a request is present
// LOW    | accessing half-word 0 (data[15:0]) for WAIT_CYCLES cycles
// HIGH   | accessing half-word 1 (data[31:16]) for WAIT_CYCLES cycles
// DONE   | one-cycle ready pulse that lets the pipeline advance
module sram_data_mem_ctrl #(
  parameter logic [31:0] DATA_MEM_BASE = 32'd1024,
  parameter int          SRAM_ADDR_W   = 18,
  parameter int          WAIT_CYCLES   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_data_mem_ctrl_if.slave    bus,
  inout  wire  [15:0]            sram_dq,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_we_n,
  output logic                   sram_oe_n
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int             CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam int             WIDX_W   = SRAM_ADDR_W - 1;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              op_wr;
  logic [15:0]       buffer;
  logic [31:0]       rdata_q;

  logic              req;
  logic              cnt_last;
  logic              half;
  logic              active;
  logic              drive_dq;
  logic [WIDX_W-1:0] word_lo;

  assign req      = bus.mem_read | bus.mem_write;
  assign cnt_last = (cnt == CNT_LAST);
  assign half     = (state == S_HIGH);
  assign active   = (state == S_LOW) | (state == S_HIGH);
  assign drive_dq = active & op_wr;

  // Out-of-range addresses wrap: only the low word-index bits reach the pins.
  assign word_lo   = WIDX_W'((bus.address - DATA_MEM_BASE) >> 2);
  assign sram_addr = {word_lo, half};

  // Pin controls decode straight from state so an async reset releases them at once.
  assign sram_we_n = ~drive_dq;
  assign sram_oe_n = ~(active & ~op_wr);
  assign sram_dq   = drive_dq ? (half ? bus.wdata[31:16] : bus.wdata[15:0]) : 16'bz;

  assign bus.ready = ((state == S_IDLE) & ~req) | (state == S_DONE);
  assign bus.rdata = rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_wr   <= 1'b0;
      buffer  <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            state <= S_LOW;
            cnt   <= '0;
            op_wr <= bus.mem_write;
          end
        end
        S_LOW: begin
          if (cnt_last) begin
            state <= S_HIGH;
            cnt   <= '0;
            if (!op_wr) buffer <= sram_dq;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (cnt_last) begin
            state <= S_DONE;
            cnt   <= '0;
            if (!op_wr) rdata_q <= {sram_dq, buffer};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_data_mem_ctrl.md
Name: sram_data_mem_ctrl

Overview:
- MEM-stage responder for the data-memory requests issued by the execute stage: the ALU result is the byte address, the forwarded second operand is the store data, and mem_read/mem_write are the command.
- Serves each 32-bit access as two sequential 16-bit accesses to an external SRAM, low half first.
- Drops ready while busy; the pipeline freezes all stages until ready returns high.

Parameters:
- DATA_MEM_BASE, 1024, byte address mapped to SRAM word 0.
- SRAM_ADDR_W, 18, SRAM half-word address width.
- WAIT_CYCLES, 2, cycles per half-word access; legal range >=1.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_read  in  1  read request; held stable by the frozen pipeline until ready.
- mem_write  in  1  write request; same hold rule.
- address  in  32  byte address from the ALU result.
- wdata  in  32  store data from the forwarded second operand.
- rdata  out  32  load data, registered.
- ready  out  1  combinational; low means freeze the pipeline.
- sram_dq  inout  16  SRAM data bus.
- sram_addr  out  SRAM_ADDR_W  SRAM half-word address.
- sram_we_n  out  1  SRAM write enable, active-low.
- sram_oe_n  out  1  SRAM output enable, active-low.

Behaviour:
- Address mapping:
  - word_idx = (address - DATA_MEM_BASE) >> 2, computed modulo 2^32; address[1:0] are ignored.
  - sram_addr = {word_idx[SRAM_ADDR_W-2:0], half}; half=0 is data[15:0], half=1 is data[31:16].
  - Upper bits of word_idx are truncated, so out-of-range addresses wrap silently.
- FSM states IDLE, LOW, HIGH, DONE; wait counter cnt runs 0..WAIT_CYCLES-1.
- IDLE:
  - A request (mem_read|mem_write) moves to LOW with cnt=0; the operation is latched as op_wr = mem_write.
  - If both mem_read and mem_write are asserted, the write wins and rdata is untouched.
- LOW:
  - cnt increments each cycle; at cnt=WAIT_CYCLES-1 go to HIGH and reset cnt to 0.
  - For a read, sram_dq[15:0] is sampled into an internal buffer on that edge.
- HIGH:
  - Same counting rule; on the last cycle go to DONE.
  - For a read, rdata <= {sram_dq, buffer} on that edge.
- DONE: lasts one cycle, then returns to IDLE unconditionally.
- ready = (state==IDLE & ~(mem_read|mem_write)) | state==DONE.
  - A request therefore sees ready low for 1+2*WAIT_CYCLES cycles, then high for exactly one cycle.
  - With WAIT_CYCLES=2: request visible at cycle 0, ready low in cycles 0-4, high in cycle 5.
- Back-to-back requests: after DONE the pipeline advances. A new request present in the following IDLE cycle starts immediately, so there is no gap beyond the IDLE cycle.
- SRAM pins:
  - Write in LOW/HIGH: sram_we_n=0, sram_oe_n=1, sram_dq driven with wdata half.
  - Read in LOW/HIGH: sram_we_n=1, sram_oe_n=0, sram_dq high-Z.
  - IDLE and DONE: sram_we_n=1, sram_oe_n=1, sram_dq high-Z, sram_addr = low-half address of the current input (don't-care).
- rdata holds its last value across writes and idle periods; it is valid from the DONE cycle of a read.
- Inputs changing mid-operation are a protocol violation. The controller uses live address/wdata, so the pipeline must keep them stable.
- Reset (asynchronous, at any time including mid-access):
  - state=IDLE, cnt=0, buffer=0, rdata=0.
  - sram_we_n=1, sram_oe_n=1, sram_dq high-Z immediately.
  - No partial write completes after reset is asserted.
  - ready reflects the inputs once rst is deasserted.

Test Plan:
- Write 0xDEADBEEF at address 1024, then read 1024, WAIT_CYCLES=2 -> the SRAM model sees half-address 0 = 0xBEEF and 1 = 0xDEAD; the read returns rdata=0xDEADBEEF in its DONE cycle; ready low exactly 5 cycles per access.
- Write 0x12345678 at 1028, read 1028, then read 1030 -> half-addresses 2/3 are written; both reads return 0x12345678 because the low address bits are ignored.
- Both mem_read and mem_write asserted, address 1032, wdata 0xA5A5A5A5 -> write performed (sram_we_n low 4 cycles); rdata keeps its previous value.
- Two consecutive reads (1024, then 1028) presented as the pipeline advances -> second access starts the cycle after DONE; ready pattern 0,0,0,0,0,1,0,0,0,0,0,1.
- rst pulled low during HIGH of a write to 1036 -> sram_we_n=1 and dq high-Z asynchronously; the half-word at address 7 is unmodified; rdata=0; after release with no request, ready=1.
- Address 1020 (below base) read -> word_idx wraps; sram_addr = {all ones[SRAM_ADDR_W-2:0], half}; no hang, and ready returns after 5 cycles.
